// File: rtl/seq_detect_param.sv
// Serial pattern detector for a valid-qualified bit stream. It supports overlapping or
// non-overlapping detection and keeps a saturating match counter with a sticky saturation flag.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_vld,
    input  logic             ovl_en,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // The completing bit always pushes the oldest bit out of the window.
    // Only the newest PAT_W-1 bits of history therefore ever feed a comparison.
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_out;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sat;

    logic [PAT_W-1:0]  w_window;
    logic              w_match;

    assign w_window = {r_hist, in};
    assign w_match  = in_vld && (w_window == PATTERN) && (r_fill >= FILL_THR);

    // NOTE: every register here is written with <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_out <= w_match;

            if (in_vld) begin
                r_hist <= w_window[PAT_W-2:0];
                if (w_match && !ovl_en)
                    r_fill <= '0;
                else if (r_fill != FILL_FULL)
                    r_fill <= r_fill + FILL_W'(1);
            end

            // Clear takes priority, but a match on the same edge is still counted.
            if (clr_cnt) begin
                r_cnt <= w_match ? CNT_W'(1) : '0;
                r_sat <= 1'b0;
            end else if (w_match) begin
                if (r_cnt == CNT_MAX)
                    r_sat <= 1'b1;
                else
                    r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out       = r_out;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param. Three instances (defaults, CNT_W=2, PAT_W=6) share one stream and are
// checked every cycle against a stream model, plus directed literal expectations.
module tb_seq_detect_param;
    localparam int N = 3;

    logic clk;
    logic rst;
    logic in;
    logic in_vld;
    logic ovl_en;
    logic clr_cnt;

    logic       out0, out1, out2;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;
    logic       sat0, sat1, sat2;

    seq_detect_param dut0 (
        .clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .ovl_en(ovl_en), .clr_cnt(clr_cnt),
        .out(out0), .match_cnt(cnt0), .cnt_sat(sat0)
    );

    seq_detect_param #(.CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .ovl_en(ovl_en), .clr_cnt(clr_cnt),
        .out(out1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    seq_detect_param #(.PAT_W(6), .PATTERN(6'b101010)) dut2 (
        .clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .ovl_en(ovl_en), .clr_cnt(clr_cnt),
        .out(out2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit done    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- stream model ----------------
    // Each instance keeps every accepted bit since the last restart (reset or non-overlapping hit).
    // A hit means the newest pw bits equal the pattern and at least pw bits have been seen.
    int          pw  [N] = '{4, 4, 6};
    logic [63:0] pat [N] = '{64'hD, 64'hD, 64'h2A};
    int          cw  [N] = '{8, 2, 8};

    logic [63:0] m_seen  [N] = '{64'd0, 64'd0, 64'd0};
    int          m_nbits [N] = '{0, 0, 0};
    bit          m_out   [N] = '{1'b0, 1'b0, 1'b0};
    int          m_cnt   [N] = '{0, 0, 0};
    bit          m_sat   [N] = '{1'b0, 1'b0, 1'b0};

    logic [63:0] m_next;
    logic [63:0] m_mask;
    bit          m_hit;

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_seen[k]  = '0;
                m_nbits[k] = 0;
                m_out[k]   = 1'b0;
                m_cnt[k]   = 0;
                m_sat[k]   = 1'b0;
            end else begin
                m_hit  = 1'b0;
                m_mask = (64'd1 << pw[k]) - 64'd1;
                if (in_vld) begin
                    m_next     = {m_seen[k][62:0], in};
                    m_hit      = ((m_nbits[k] + 1) >= pw[k]) && ((m_next & m_mask) == pat[k]);
                    m_seen[k]  = m_next;
                    m_nbits[k] = (m_hit && !ovl_en) ? 0 : m_nbits[k] + 1;
                end
                m_out[k] = m_hit;
                if (clr_cnt) begin
                    m_cnt[k] = m_hit ? 1 : 0;
                    m_sat[k] = 1'b0;
                end else if (m_hit) begin
                    if (m_cnt[k] == (1 << cw[k]) - 1) m_sat[k] = 1'b1;
                    else m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("model out0", 32'(out0), 32'(m_out[0]));
            check("model cnt0", 32'(cnt0), 32'(m_cnt[0]));
            check("model sat0", 32'(sat0), 32'(m_sat[0]));
            check("model out1", 32'(out1), 32'(m_out[1]));
            check("model cnt1", 32'(cnt1), 32'(m_cnt[1]));
            check("model sat1", 32'(sat1), 32'(m_sat[1]));
            check("model out2", 32'(out2), 32'(m_out[2]));
            check("model cnt2", 32'(cnt2), 32'(m_cnt[2]));
            check("model sat2", 32'(sat2), 32'(m_sat[2]));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic dut_out(input int which);
        if (which == 0) return out0;
        if (which == 1) return out1;
        return out2;
    endfunction

    // Present one bit for one edge; returns on the following falling edge.
    task automatic send(input logic b);
        in     = b;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    // The first bit sent is s[n-1]. e[i] is the expected out after bit s[i].
    task automatic run_seq(input string tag, input int which, input int n,
                           input logic [15:0] s, input logic [15:0] e);
        for (int i = n - 1; i >= 0; i--) begin
            send(s[i]);
            check($sformatf("%s bit%0d out", tag, n - i), 32'(dut_out(which)), 32'(e[i]));
        end
    endtask

    task automatic do_reset;
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_gap(input logic b, input logic exp_out, input int idx);
        send(b);
        check($sformatf("gap bit%0d out", idx), 32'(out0), 32'(exp_out));
        for (int g = 0; g < 3; g++) begin
            in = ~in;
            @(negedge clk);
            check($sformatf("gap%0d idle%0d out", idx, g), 32'(out0), 32'd0);
        end
    endtask

    initial begin
        in      = 1'b0;
        in_vld  = 1'b0;
        ovl_en  = 1'b1;
        clr_cnt = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("reset out", 32'(out0), 32'd0);
        check("reset cnt", 32'(cnt0), 32'd0);
        check("reset sat", 32'(sat0), 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Overlapping mode, stream 1101101: hits after bits 4 and 7.
        ovl_en = 1'b1;
        run_seq("ovl", 0, 7, 16'b1101101, 16'b0001001);
        check("ovl cnt", 32'(cnt0), 32'd2);

        // Non-overlapping mode, same stream and then 1101 appended: hits after bits 4 and 11.
        do_reset();
        ovl_en = 1'b0;
        run_seq("novl", 0, 7, 16'b1101101, 16'b0001000);
        check("novl cnt7", 32'(cnt0), 32'd1);
        run_seq("novl tail", 0, 4, 16'b1101, 16'b0001);
        check("novl cnt11", 32'(cnt0), 32'd2);

        // Invalid gaps with in toggling must not break the sequence.
        do_reset();
        ovl_en = 1'b1;
        send_gap(1'b1, 1'b0, 1);
        send_gap(1'b1, 1'b0, 2);
        send_gap(1'b0, 1'b0, 3);
        send_gap(1'b1, 1'b1, 4);
        check("gap cnt", 32'(cnt0), 32'd1);

        // Asynchronous reset between edges after a partial 1,1,0.
        run_seq("pre-rst", 0, 3, 16'b110, 16'b000);
        #2 rst = 1'b1;
        #1;
        check("async out", 32'(out0), 32'd0);
        check("async cnt", 32'(cnt0), 32'd0);
        check("async sat", 32'(sat0), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        run_seq("post-rst lone", 0, 1, 16'b1, 16'b0);
        run_seq("post-rst", 0, 4, 16'b1101, 16'b0001);
        check("post-rst cnt", 32'(cnt0), 32'd1);

        // Saturation of the 2-bit counter, then clear coincident with a hit.
        do_reset();
        ovl_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            run_seq($sformatf("sat m%0d", j + 1), 1, 4, 16'b1101, 16'b0001);
            check($sformatf("sat m%0d cnt", j + 1), 32'(cnt1), (j < 3) ? 32'(j + 1) : 32'd3);
            check($sformatf("sat m%0d flag", j + 1), 32'(sat1), (j >= 3) ? 32'd1 : 32'd0);
        end
        run_seq("sat m6", 1, 3, 16'b110, 16'b000);
        clr_cnt = 1'b1;
        send(1'b1);
        clr_cnt = 1'b0;
        check("clr+hit out", 32'(out1), 32'd1);
        check("clr+hit cnt", 32'(cnt1), 32'd1);
        check("clr+hit flag", 32'(sat1), 32'd0);

        // Six-bit pattern 101010 in overlapping mode: hits after bits 6, 8 and 10.
        do_reset();
        ovl_en = 1'b1;
        run_seq("p6", 2, 10, 16'b1010101010, 16'b0000010101);
        check("p6 cnt", 32'(cnt2), 32'd3);

        @(negedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
